// File: rtl/ika9958_vram_sched.sv
// VRAM access-slot scheduler: splits each line into 4-dot slots for refresh,
// display, CPU and command engine, and routes read data back to the slot owner.
module ika9958_vram_sched #(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_phiA,
  input  logic        i_RST,
  input  logic        i_CEN,
  input  logic [8:0]  i_HCNTR,
  input  logic        i_BL,
  input  logic        i_VACT,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WE,
  input  logic [16:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_WDATA,
  output logic        o_CPU_ACK,
  output logic        o_CPU_RVALID,
  input  logic        i_CMD_REQ,
  input  logic        i_CMD_WE,
  input  logic [16:0] i_CMD_ADDR,
  input  logic [7:0]  i_CMD_WDATA,
  output logic        o_CMD_ACK,
  output logic        o_CMD_RVALID,
  output logic [7:0]  o_RDATA,
  output logic [16:0] o_VA,
  output logic        o_VWE,
  output logic        o_VRE,
  output logic [7:0]  o_VWDATA,
  input  logic [7:0]  i_VRDATA,
  output logic        o_REFRESH
);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic        slot, is_ref, is_disp, free_slot;
  logic        cpu_win, cmd_win, grant, sel_we;
  logic [16:0] sel_addr;
  logic [7:0]  sel_wdata;

  logic        cpu_ack_q, cpu_ack_d, cmd_ack_q, cmd_ack_d;
  logic        cpu_rvalid_q, cpu_rvalid_d, cmd_rvalid_q, cmd_rvalid_d;
  logic        vwe_q, vwe_d, vre_q, vre_d, refresh_q, refresh_d;
  logic [16:0] va_q, va_d;
  logic [7:0]  vwdata_q, vwdata_d, rdata_q, rdata_d;
  logic [2:0]  starve_q, starve_d;
  // Return pipeline: pv = read in flight, po = owner (1 = command engine).
  logic [RD_LAT-1:0] pv_q, pv_d, po_q, po_d;

  always_comb begin
    slot      = i_CEN & (i_HCNTR[1:0] == 2'b00);
    is_ref    = (i_HCNTR == 9'd0) | (i_HCNTR == 9'd168);
    is_disp   = i_BL & i_VACT & (i_HCNTR < 9'd256) & ~i_HCNTR[2];
    free_slot = slot & ~is_ref & ~is_disp;
    cmd_win   = free_slot & i_CMD_REQ & (~i_CPU_REQ | (starve_q == STARVE_LIM));
    cpu_win   = free_slot & i_CPU_REQ & ~cmd_win;
    grant     = cpu_win | cmd_win;
    sel_we    = cmd_win ? i_CMD_WE    : i_CPU_WE;
    sel_addr  = cmd_win ? i_CMD_ADDR  : i_CPU_ADDR;
    sel_wdata = cmd_win ? i_CMD_WDATA : i_CPU_WDATA;
  end

  always_comb begin
    cpu_ack_d    = cpu_ack_q;
    cmd_ack_d    = cmd_ack_q;
    cpu_rvalid_d = cpu_rvalid_q;
    cmd_rvalid_d = cmd_rvalid_q;
    vwe_d        = vwe_q;
    vre_d        = vre_q;
    refresh_d    = refresh_q;
    va_d         = va_q;
    vwdata_d     = vwdata_q;
    rdata_d      = rdata_q;
    starve_d     = starve_q;
    pv_d         = pv_q;
    po_d         = po_q;
    if (i_CEN) begin
      cpu_ack_d = cpu_win;
      cmd_ack_d = cmd_win;
      refresh_d = slot & is_ref;
      vwe_d     = grant & sel_we;
      vre_d     = grant & ~sel_we;
      if (grant) begin
        va_d = sel_addr;
        if (sel_we) vwdata_d = sel_wdata;
      end
      if (cmd_win) begin
        starve_d = 3'd0;
      end else if (cpu_win && i_CMD_REQ && starve_q != STARVE_LIM) begin
        starve_d = starve_q + 3'd1;
      end
      pv_d[0] = grant & ~sel_we;
      po_d[0] = cmd_win;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_d[i] = pv_q[i-1];
        po_d[i] = po_q[i-1];
      end
      cpu_rvalid_d = pv_q[RD_LAT-1] & ~po_q[RD_LAT-1];
      cmd_rvalid_d = pv_q[RD_LAT-1] & po_q[RD_LAT-1];
      if (pv_q[RD_LAT-1]) rdata_d = i_VRDATA;
    end
  end

  always_ff @(posedge i_phiA) begin
    if (i_RST) begin
      cpu_ack_q    <= 1'b0;
      cmd_ack_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cmd_rvalid_q <= 1'b0;
      vwe_q        <= 1'b0;
      vre_q        <= 1'b0;
      refresh_q    <= 1'b0;
      va_q         <= 17'd0;
      vwdata_q     <= 8'd0;
      rdata_q      <= 8'd0;
      starve_q     <= 3'd0;
      pv_q         <= '0;
      po_q         <= '0;
    end else begin
      cpu_ack_q    <= cpu_ack_d;
      cmd_ack_q    <= cmd_ack_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cmd_rvalid_q <= cmd_rvalid_d;
      vwe_q        <= vwe_d;
      vre_q        <= vre_d;
      refresh_q    <= refresh_d;
      va_q         <= va_d;
      vwdata_q     <= vwdata_d;
      rdata_q      <= rdata_d;
      starve_q     <= starve_d;
      pv_q         <= pv_d;
      po_q         <= po_d;
    end
  end

  assign o_CPU_ACK    = cpu_ack_q;
  assign o_CMD_ACK    = cmd_ack_q;
  assign o_CPU_RVALID = cpu_rvalid_q;
  assign o_CMD_RVALID = cmd_rvalid_q;
  assign o_VWE        = vwe_q;
  assign o_VRE        = vre_q;
  assign o_REFRESH    = refresh_q;
  assign o_VA         = va_q;
  assign o_VWDATA     = vwdata_q;
  assign o_RDATA      = rdata_q;
endmodule

// File: tb/tb_ika9958_vram_sched.sv
// Bench for ika9958_vram_sched: directed line scenarios plus random traffic,
// every cycle compared against a slot-level reference model.
module tb_ika9958_vram_sched;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_RST, i_CEN, i_BL, i_VACT;
  logic [8:0]  i_HCNTR;
  logic        i_CPU_REQ, i_CPU_WE, i_CMD_REQ, i_CMD_WE;
  logic [16:0] i_CPU_ADDR, i_CMD_ADDR;
  logic [7:0]  i_CPU_WDATA, i_CMD_WDATA, i_VRDATA;
  logic        o_CPU_ACK, o_CPU_RVALID, o_CMD_ACK, o_CMD_RVALID;
  logic        o_VWE, o_VRE, o_REFRESH;
  logic [16:0] o_VA;
  logic [7:0]  o_VWDATA, o_RDATA;

  ika9958_vram_sched #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .i_phiA(clk), .i_RST(i_RST), .i_CEN(i_CEN), .i_HCNTR(i_HCNTR),
    .i_BL(i_BL), .i_VACT(i_VACT),
    .i_CPU_REQ(i_CPU_REQ), .i_CPU_WE(i_CPU_WE), .i_CPU_ADDR(i_CPU_ADDR),
    .i_CPU_WDATA(i_CPU_WDATA), .o_CPU_ACK(o_CPU_ACK), .o_CPU_RVALID(o_CPU_RVALID),
    .i_CMD_REQ(i_CMD_REQ), .i_CMD_WE(i_CMD_WE), .i_CMD_ADDR(i_CMD_ADDR),
    .i_CMD_WDATA(i_CMD_WDATA), .o_CMD_ACK(o_CMD_ACK), .o_CMD_RVALID(o_CMD_RVALID),
    .o_RDATA(o_RDATA), .o_VA(o_VA), .o_VWE(o_VWE), .o_VRE(o_VRE),
    .o_VWDATA(o_VWDATA), .i_VRDATA(i_VRDATA), .o_REFRESH(o_REFRESH)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: expected output values and outstanding-read countdowns.
  logic        e_cpu_ack, e_cmd_ack, e_cpu_rv, e_cmd_rv, e_vwe, e_vre, e_ref;
  logic [16:0] e_va;
  logic [7:0]  e_vwdata, e_rdata;
  int          starve;
  int          ret_cnt[$];
  bit          ret_own[$];

  int hcnt, cyc, edge_h;
  bit edge_en, edge_cen;
  int cpu_mode, cmd_mode;  // 0 one-shot, 1 continuous, 2 random
  int log_h[$];
  bit log_own[$];
  int ref_h[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit is_slot, is_ref, is_disp, free, cpu_w, cmd_w, we;
    if (i_RST) begin
      {e_cpu_ack, e_cmd_ack, e_cpu_rv, e_cmd_rv, e_vwe, e_vre, e_ref} = '0;
      e_va = '0; e_vwdata = '0; e_rdata = '0; starve = 0;
      ret_cnt.delete(); ret_own.delete();
    end else if (i_CEN) begin
      e_cpu_rv = 0; e_cmd_rv = 0;
      foreach (ret_cnt[k]) ret_cnt[k]--;
      while (ret_cnt.size() > 0 && ret_cnt[0] == 0) begin
        if (ret_own[0]) e_cmd_rv = 1; else e_cpu_rv = 1;
        e_rdata = i_VRDATA;
        void'(ret_cnt.pop_front());
        void'(ret_own.pop_front());
      end
      is_slot = (hcnt % 4) == 0;
      is_ref  = is_slot && (hcnt == 0 || hcnt == 168);
      is_disp = is_slot && !is_ref && i_BL && i_VACT && hcnt < 256 && ((hcnt / 4) % 2 == 0);
      free    = is_slot && !is_ref && !is_disp;
      cmd_w   = free && i_CMD_REQ && (!i_CPU_REQ || starve == STARVE_MAX);
      cpu_w   = free && i_CPU_REQ && !cmd_w;
      if (cmd_w) starve = 0;
      else if (cpu_w && i_CMD_REQ && starve < STARVE_MAX) starve++;
      e_cpu_ack = cpu_w; e_cmd_ack = cmd_w; e_ref = is_ref;
      e_vwe = 0; e_vre = 0;
      if (cpu_w || cmd_w) begin
        we   = cmd_w ? i_CMD_WE : i_CPU_WE;
        e_va = cmd_w ? i_CMD_ADDR : i_CPU_ADDR;
        if (we) begin
          e_vwe = 1;
          e_vwdata = cmd_w ? i_CMD_WDATA : i_CPU_WDATA;
        end else begin
          e_vre = 1;
          ret_cnt.push_back(RD_LAT);
          ret_own.push_back(cmd_w);
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("cpu_ack", o_CPU_ACK, e_cpu_ack);
    chk("cmd_ack", o_CMD_ACK, e_cmd_ack);
    chk("cpu_rvalid", o_CPU_RVALID, e_cpu_rv);
    chk("cmd_rvalid", o_CMD_RVALID, e_cmd_rv);
    chk("vwe", o_VWE, e_vwe);
    chk("vre", o_VRE, e_vre);
    chk("refresh", o_REFRESH, e_ref);
    chk("va", o_VA, e_va);
    chk("vwdata", o_VWDATA, e_vwdata);
    chk("rdata", o_RDATA, e_rdata);
  endtask

  task automatic new_cpu();
    i_CPU_REQ = 1'($urandom_range(0, 1)); i_CPU_WE = 1'($urandom_range(0, 1));
    i_CPU_ADDR = 17'($urandom); i_CPU_WDATA = 8'($urandom);
  endtask

  task automatic new_cmd();
    i_CMD_REQ = 1'($urandom_range(0, 1)); i_CMD_WE = 1'($urandom_range(0, 1));
    i_CMD_ADDR = 17'($urandom); i_CMD_WDATA = 8'($urandom);
  endtask

  task automatic cycle();
    i_HCNTR  = 9'(hcnt);
    edge_h   = hcnt;
    edge_cen = i_CEN;
    edge_en  = i_CEN && !i_RST;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    if (edge_en) begin
      if (o_CPU_ACK) begin log_h.push_back(edge_h); log_own.push_back(1'b0); end
      if (o_CMD_ACK) begin log_h.push_back(edge_h); log_own.push_back(1'b1); end
      if (o_REFRESH) ref_h.push_back(edge_h);
    end
    if (edge_cen) hcnt = (hcnt == 340) ? 0 : hcnt + 1;
    if (edge_en && e_cpu_ack) begin
      if (cpu_mode == 0) i_CPU_REQ = 0;
      else if (cpu_mode == 2) new_cpu();
    end else if (cpu_mode == 2 && !i_CPU_REQ && $urandom_range(0, 3) == 0) begin
      new_cpu(); i_CPU_REQ = 1;
    end
    if (edge_en && e_cmd_ack) begin
      if (cmd_mode == 0) i_CMD_REQ = 0;
      else if (cmd_mode == 2) new_cmd();
    end else if (cmd_mode == 2 && !i_CMD_REQ && $urandom_range(0, 3) == 0) begin
      new_cmd(); i_CMD_REQ = 1;
    end
  endtask

  task automatic do_reset();
    i_RST = 1; cycle(); cycle(); i_RST = 0;
  endtask

  function automatic int next_free_blank(input int h);
    int x = h;
    for (int k = 0; k < 400; k++) begin
      if (x % 4 == 0 && x != 0 && x != 168) return x;
      x = (x == 340) ? 0 : x + 1;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    log_h.delete(); log_own.delete(); ref_h.delete();
  endtask

  initial begin
    int a, r, cnt, exp_h, got_h;
    i_RST = 1; i_CEN = 1; i_BL = 0; i_VACT = 0; i_HCNTR = 0;
    i_CPU_REQ = 0; i_CPU_WE = 0; i_CPU_ADDR = 0; i_CPU_WDATA = 0;
    i_CMD_REQ = 0; i_CMD_WE = 0; i_CMD_ADDR = 0; i_CMD_WDATA = 0; i_VRDATA = 0;
    hcnt = 0; cyc = 0; cpu_mode = 0; cmd_mode = 0;

    // Reset state
    do_reset();
    chk("reset_va", o_VA, 17'd0);
    chk("reset_vwdata", o_VWDATA, 8'd0);
    chk("reset_strobes", {o_CPU_ACK, o_CMD_ACK, o_VWE, o_VRE, o_REFRESH}, 5'd0);

    // Blank line: CPU write granted at slot 8, refresh only at 0 and 168
    hcnt = 0; i_BL = 1; i_VACT = 0; clear_logs();
    for (int k = 0; k < 400 && hcnt != 5; k++) cycle();
    i_CPU_REQ = 1; i_CPU_WE = 1; i_CPU_ADDR = 17'h1ABCD; i_CPU_WDATA = 8'h5A;
    for (int k = 0; k < 400 && hcnt != 171; k++) begin
      cycle();
      if (edge_h == 8) begin
        chk("wr_ack", o_CPU_ACK, 1'b1);
        chk("wr_vwe", o_VWE, 1'b1);
        chk("wr_va", o_VA, 17'h1ABCD);
        chk("wr_vwdata", o_VWDATA, 8'h5A);
      end
    end
    chk("wr_grants", log_h.size(), 1);
    if (log_h.size() > 0) chk("wr_slot", log_h[0], 8);
    chk("ref_count", ref_h.size(), 2);
    if (ref_h.size() == 2) begin
      chk("ref_slot0", ref_h[0], 0);
      chk("ref_slot168", ref_h[1], 168);
    end

    // Active line: display slots skipped
    do_reset();
    hcnt = 0; i_BL = 1; i_VACT = 1; cpu_mode = 1; clear_logs();
    i_CPU_REQ = 1; i_CPU_WE = 0; i_CPU_ADDR = 17'h00400;
    for (int k = 0; k < 400 && hcnt != 22; k++) cycle();
    chk("act_grants", log_h.size(), 3);
    if (log_h.size() == 3) begin
      chk("act_first", log_h[0], 4);
      chk("act_second", log_h[1], 12);
      chk("act_third", log_h[2], 20);
    end
    cpu_mode = 0; i_CPU_REQ = 0;
    for (int k = 0; k < 6; k++) cycle();

    // Contested slots: CPU x4 then CMD, repeating
    do_reset();
    hcnt = 1; i_VACT = 0; cpu_mode = 1; cmd_mode = 1; clear_logs();
    i_CPU_REQ = 1; i_CPU_WE = 1; i_CPU_ADDR = 17'h00100; i_CPU_WDATA = 8'h11;
    i_CMD_REQ = 1; i_CMD_WE = 1; i_CMD_ADDR = 17'h00200; i_CMD_WDATA = 8'h22;
    for (int k = 0; k < 400 && hcnt != 42; k++) cycle();
    chk("arb_grants", log_h.size(), 10);
    for (int k = 0; k < 10 && k < log_h.size(); k++) begin
      chk($sformatf("arb_owner%0d", k), log_own[k], (k % 5) == 4);
      chk($sformatf("arb_slot%0d", k), log_h[k], 4 + 4 * k);
    end
    cpu_mode = 0; cmd_mode = 0; i_CPU_REQ = 0; i_CMD_REQ = 0;

    // CMD read latency and return routing
    do_reset();
    hcnt = 1; i_VRDATA = 8'hC3;
    i_CMD_REQ = 1; i_CMD_WE = 0; i_CMD_ADDR = 17'h00010;
    a = -100; r = -1;
    for (int k = 0; k < 20 && r < 0; k++) begin
      cycle();
      if (o_CMD_ACK && a < 0) begin
        a = cyc;
        chk("cmd_rd_va", o_VA, 17'h00010);
        chk("cmd_rd_vre", o_VRE, 1'b1);
      end
      if (o_CMD_RVALID && r < 0) begin
        r = cyc;
        chk("cmd_rd_data", o_RDATA, 8'hC3);
        chk("cmd_rd_cpu_rv", o_CPU_RVALID, 1'b0);
      end
    end
    chk("cmd_rd_lat", r - a, RD_LAT);

    // Clock-enable stall between issue and return
    i_VRDATA = 8'h3C;
    i_CPU_REQ = 1; i_CPU_WE = 0; i_CPU_ADDR = 17'h1F0F0;
    a = -100; r = -1;
    for (int k = 0; k < 20 && a < 0; k++) begin
      cycle();
      if (o_CPU_ACK) a = cyc;
    end
    i_CEN = 0;
    repeat (3) cycle();
    i_CEN = 1;
    for (int k = 0; k < 20 && r < 0; k++) begin
      cycle();
      if (o_CPU_RVALID) begin
        r = cyc;
        chk("stall_data", o_RDATA, 8'h3C);
      end
    end
    chk("stall_lat", r - a, RD_LAT + 3);

    // Reset with a read in flight
    i_CPU_REQ = 1; i_CPU_WE = 0; i_CPU_ADDR = 17'h0AAAA; i_VRDATA = 8'h99;
    a = -1;
    for (int k = 0; k < 20 && a < 0; k++) begin
      cycle();
      if (o_CPU_ACK) a = cyc;
    end
    chk("rst_ack_seen", a > 0, 1'b1);
    cycle();
    i_RST = 1; cycle(); i_RST = 0;
    chk("rst_outputs", {o_CPU_ACK, o_CMD_ACK, o_CPU_RVALID, o_CMD_RVALID, o_VWE, o_VRE, o_REFRESH}, 7'd0);
    chk("rst_va", o_VA, 17'd0);
    chk("rst_rdata", o_RDATA, 8'd0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (o_CPU_RVALID || o_CMD_RVALID) cnt++;
    end
    chk("rst_no_rvalid", cnt, 0);
    exp_h = next_free_blank(hcnt);
    i_CPU_REQ = 1; i_CPU_WE = 1; i_CPU_ADDR = 17'h00077; i_CPU_WDATA = 8'hE7;
    got_h = -1;
    for (int k = 0; k < 20 && got_h < 0; k++) begin
      cycle();
      if (o_CPU_ACK) got_h = edge_h;
    end
    chk("rst_regrant", got_h, exp_h);

    // Line wrap: slot 340 is free, slot 0 is refresh
    hcnt = 337; clear_logs();
    i_CPU_REQ = 1; i_CPU_WE = 1; i_CPU_ADDR = 17'h15555; i_CPU_WDATA = 8'hA5;
    for (int k = 0; k < 20 && hcnt != 2; k++) cycle();
    chk("wrap_grants", log_h.size(), 1);
    if (log_h.size() > 0) chk("wrap_slot", log_h[0], 340);
    chk("wrap_ref", ref_h.size(), 1);
    if (ref_h.size() > 0) chk("wrap_ref_slot", ref_h[0], 0);

    // Random traffic against the model
    cpu_mode = 2; cmd_mode = 2;
    for (int k = 0; k < 4000; k++) begin
      i_CEN    = ($urandom_range(0, 4) != 0);
      i_RST    = ($urandom_range(0, 399) == 0);
      i_VRDATA = 8'($urandom);
      if ($urandom_range(0, 99) == 0) i_BL = ~i_BL;
      if (hcnt == 0) i_VACT = 1'($urandom_range(0, 1));
      cycle();
    end
    i_RST = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
